// File: rtl/layer_fetch_sequencer_pkg.sv
// Shared types and constants for the layer fetch sequencer (states, transparent pixel, index width helper).
package layer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [23:0] TRANSPARENT_PIX = 24'h000000;
    localparam int          NUM_LAYERS_DEF  = 5;

    // Width of a layer index; a single layer still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LAYER_IDX_W = idx_w(NUM_LAYERS_DEF);

endpackage

// File: rtl/layer_fetch_sequencer_if.sv
// Coordinate, layer-memory and bundle-output handshakes of the layer fetch sequencer.
// Every channel is valid/ready: a transfer happens on a rising edge where both are high, and the
// sender keeps valid and its payload stable until that edge.
interface layer_fetch_sequencer_if #(
    parameter int NUM_LAYERS = 5,
    parameter int PIX_W      = 24,
    parameter int X_W        = 10,
    parameter int Y_W        = 10
);
    import layer_seq_pkg::*;

    localparam int IW = idx_w(NUM_LAYERS);

    logic                        start_valid;
    logic                        start_ready;
    logic [X_W-1:0]              start_x;
    logic [Y_W-1:0]              start_y;
    logic [NUM_LAYERS-1:0]       layer_en;
    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic [IW-1:0]               mem_req_layer;
    logic [X_W-1:0]              mem_req_x;
    logic [Y_W-1:0]              mem_req_y;
    logic                        mem_rsp_valid;
    logic [PIX_W-1:0]            mem_rsp_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_LAYERS*PIX_W-1:0] out_pixels;
    logic                        busy;
    logic                        rsp_unexp;

    modport slave (
        input  start_valid, start_x, start_y, layer_en,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output start_ready, mem_req_valid, mem_req_layer, mem_req_x, mem_req_y,
        output out_valid, out_pixels, busy, rsp_unexp
    );

    modport master (
        output start_valid, start_x, start_y, layer_en,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  start_ready, mem_req_valid, mem_req_layer, mem_req_x, mem_req_y,
        input  out_valid, out_pixels, busy, rsp_unexp
    );

endinterface

// File: rtl/layer_fetch_sequencer_layer_pick.sv
// Highest-set-bit finder over the pending-layer mask: returns the top pending layer and whether any remain.
module layer_pick
    import layer_seq_pkg::*;
#(
    parameter int N  = 5,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Ascending scan: the last set bit seen wins, i.e. the highest layer.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask_i[i]) begin
                idx_o = IW'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_fetch_sequencer.sv
// Per-pixel layer fetch sequencer: one read per enabled layer, top layer first, bundled for the composer.
// Optional build macro EARLY_OPAQUE_SKIP_EN: stop fetching once a non-transparent layer pixel returns.
module layer_fetch_sequencer
    import layer_seq_pkg::*;
#(
    parameter int NUM_LAYERS = 5,
    parameter int PIX_W      = 24,
    parameter int X_W        = 10,
    parameter int Y_W        = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    layer_fetch_sequencer_if.slave bus,
    output state_e                 state_o
);

    localparam int IW = idx_w(NUM_LAYERS);

    state_e                      state_q;
    logic [NUM_LAYERS-1:0]       pend_q;
    logic [X_W-1:0]              x_q;
    logic [Y_W-1:0]              y_q;
    logic [IW-1:0]               layer_q;
    logic                        req_valid_q;
    logic                        out_valid_q;
    logic                        start_ready_q;
    logic                        busy_q;
    logic                        unexp_q;
    logic [NUM_LAYERS*PIX_W-1:0] pix_q;

    logic [NUM_LAYERS-1:0]       pick_mask_d;
    logic [IW-1:0]               pick_idx;
    logic                        pick_any;

    // Pending mask as it will be after this cycle: fresh enables in IDLE, minus the answered layer otherwise.
    always_comb begin
        pick_mask_d = bus.layer_en;
        if (state_q != IDLE) begin
            pick_mask_d = pend_q & ~(NUM_LAYERS'(1) << layer_q);
`ifdef EARLY_OPAQUE_SKIP_EN
            if (bus.mem_rsp_data != PIX_W'(TRANSPARENT_PIX)) begin
                pick_mask_d = '0;
            end
`endif
        end
    end

    layer_pick #(.N(NUM_LAYERS), .IW(IW)) u_pick (
        .mask_i (pick_mask_d),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pend_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            layer_q       <= '0;
            req_valid_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            unexp_q       <= 1'b0;
            pix_q         <= '0;
        end else begin
            if (bus.mem_rsp_valid && state_q != WAIT) begin
                unexp_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    // start_ready comes up one cycle after reset so every output is 0 while rst is high.
                    if (bus.start_valid && start_ready_q) begin
                        x_q           <= bus.start_x;
                        y_q           <= bus.start_y;
                        pend_q        <= bus.layer_en;
                        pix_q         <= '0;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        if (pick_any) begin
                            state_q     <= ISSUE;
                            layer_q     <= pick_idx;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end else begin
                        start_ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        pix_q[layer_q*PIX_W +: PIX_W] <= bus.mem_rsp_data;
                        pend_q <= pick_mask_d;
                        if (pick_any) begin
                            state_q     <= ISSUE;
                            layer_q     <= pick_idx;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q       <= IDLE;
                        out_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.start_ready   = start_ready_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_layer = layer_q;
    assign bus.mem_req_x     = x_q;
    assign bus.mem_req_y     = y_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_pixels    = pix_q;
    assign bus.busy          = busy_q;
    assign bus.rsp_unexp     = unexp_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_layer_fetch_sequencer.sv
// Bench for layer_fetch_sequencer: directed scenarios plus randomized pixels against a fetch-list reference model.
module tb_layer_fetch_sequencer;
    import layer_seq_pkg::*;

    localparam int NL = 5;
    localparam int PW = 24;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int IW = idx_w(NL);
`ifdef EARLY_OPAQUE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst;
    state_e state_o;

    layer_fetch_sequencer_if #(.NUM_LAYERS(NL), .PIX_W(PW), .X_W(XW), .Y_W(YW)) bus ();

    layer_fetch_sequencer #(.NUM_LAYERS(NL), .PIX_W(PW), .X_W(XW), .Y_W(YW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          exp_unexp = 1'b0;

    // Memory model state shared with the stimulus block.
    logic [PW-1:0] lay_data [NL];
    int            mem_lat = 1;
    int            stall_left = 0;
    bit            stray_req = 1'b0;
    int            rsp_cnt = 0;
    logic [IW-1:0] rsp_layer = '0;
    int            acc_layer_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Layer memory: answers each accepted request mem_lat edges later, optionally stalling ready.
    initial begin
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
            if (rst) begin
                rsp_cnt = 0;
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = lay_data[rsp_layer];
                end
            end else if (stray_req) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = 24'hABCDEF;
                stray_req = 1'b0;
            end
            if (bus.mem_req_valid === 1'b1 && stall_left > 0) begin
                bus.mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                bus.mem_req_ready = 1'b1;
            end
            if (!rst && bus.mem_req_valid === 1'b1 && bus.mem_req_ready) begin
                rsp_cnt   = mem_lat;
                rsp_layer = bus.mem_req_layer;
                acc_layer_q.push_back(int'(bus.mem_req_layer));
            end
        end
    end

    task automatic run_pixel(input logic [NL-1:0] en, input int lat, input int stall,
                             input int hold, input bit start_in_hold);
        logic [NL*PW-1:0] exp_pix;
        int               exp_req [$];
        int               exp_lat, lat_obs, guard, st;
        logic [XW-1:0]    x;
        logic [YW-1:0]    y;
        bit               pv;
        logic [IW-1:0]    pl;
        // Reference: enabled layers top-down; a transparent-skip build stops after the first opaque pixel.
        exp_pix = '0;
        for (int i = NL - 1; i >= 0; i--) begin
            if (en[i]) begin
                exp_req.push_back(i);
                exp_pix[i*PW +: PW] = lay_data[i];
                if (SKIP && lay_data[i] != TRANSPARENT_PIX) break;
            end
        end
        st      = (exp_req.size() > 0) ? stall : 0;
        exp_lat = 1 + exp_req.size() * (lat + 1) + st;
        x = XW'($urandom);
        y = YW'($urandom);
        mem_lat    = lat;
        stall_left = st;
        acc_layer_q.delete();

        guard = 0;
        while (bus.start_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("start_ready_idle", 128'(bus.start_ready), 128'(1));
        bus.start_valid = 1'b1;
        bus.start_x     = x;
        bus.start_y     = y;
        bus.layer_en    = en;
        bus.out_ready   = 1'b0;
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.layer_en    = NL'($urandom);
        bus.start_x     = XW'($urandom);
        bus.start_y     = YW'($urandom);
        chk("busy_after_start", 128'(bus.busy), 128'(1));

        lat_obs = 1;
        pv      = 1'b0;
        pl      = '0;
        while (bus.out_valid !== 1'b1 && lat_obs < 300) begin
            if (bus.mem_req_valid === 1'b1) begin
                chk("req_xy", 128'({bus.mem_req_x, bus.mem_req_y}), 128'({x, y}));
                if (pv) chk("req_layer_stable", 128'(bus.mem_req_layer), 128'(pl));
                pv = 1'b1;
                pl = bus.mem_req_layer;
            end else begin
                pv = 1'b0;
            end
            @(negedge clk);
            lat_obs++;
        end
        chk("out_valid", 128'(bus.out_valid), 128'(1));
        chk("latency", 128'(lat_obs), 128'(exp_lat));
        chk("out_pixels", 128'(bus.out_pixels), 128'(exp_pix));
        chk("state_done", 128'(state_o), 128'(DONE));
        chk("req_count", 128'(acc_layer_q.size()), 128'(exp_req.size()));
        for (int i = 0; i < exp_req.size() && i < acc_layer_q.size(); i++)
            chk("req_order", 128'(acc_layer_q[i]), 128'(exp_req[i]));

        for (int h = 0; h < hold; h++) begin
            bus.start_valid = start_in_hold;
            @(negedge clk);
            chk("hold_valid", 128'(bus.out_valid), 128'(1));
            chk("hold_pixels", 128'(bus.out_pixels), 128'(exp_pix));
            chk("hold_start_ready", 128'(bus.start_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready   = 1'b0;
        bus.start_valid = 1'b0;
        chk("release_valid", 128'(bus.out_valid), 128'(0));
        chk("release_busy", 128'(bus.busy), 128'(0));
        chk("release_state", 128'(state_o), 128'(IDLE));
        chk("release_start_ready", 128'(bus.start_ready), 128'(1));
        chk("no_extra_req", 128'(acc_layer_q.size()), 128'(exp_req.size()));
        chk("rsp_unexp", 128'(bus.rsp_unexp), 128'(exp_unexp));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.start_x     = '0;
        bus.start_y     = '0;
        bus.layer_en    = '0;
        bus.out_ready   = 1'b0;
        for (int i = 0; i < NL; i++) lay_data[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 128'(state_o), 128'(IDLE));
        chk("rst_start_ready", 128'(bus.start_ready), 128'(0));
        chk("rst_req_valid", 128'(bus.mem_req_valid), 128'(0));
        chk("rst_req_fields", 128'({bus.mem_req_layer, bus.mem_req_x, bus.mem_req_y}), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_pixels", 128'(bus.out_pixels), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_unexp", 128'(bus.rsp_unexp), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_start_ready", 128'(bus.start_ready), 128'(1));

        // Reset while a response is outstanding.
        for (int i = 0; i < NL; i++) lay_data[i] = PW'(24'h010101 * (i + 1));
        mem_lat         = 3;
        bus.start_valid = 1'b1;
        bus.layer_en    = '1;
        bus.start_x     = 10'd7;
        bus.start_y     = 10'd9;
        @(negedge clk);
        bus.start_valid = 1'b0;
        guard = 0;
        while (state_o !== WAIT && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("midwait_reached", 128'(state_o), 128'(WAIT));
        rst = 1'b1;
        #1;
        chk("midwait_rst_state", 128'(state_o), 128'(IDLE));
        chk("midwait_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("midwait_rst_pixels", 128'(bus.out_pixels), 128'(0));
        chk("midwait_rst_busy", 128'(bus.busy), 128'(0));
        chk("midwait_rst_req_valid", 128'(bus.mem_req_valid), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midwait_unexp_clear", 128'(bus.rsp_unexp), 128'(0));

        // All layers, L=1, mix of transparent and opaque data.
        lay_data[4] = 24'h000000;
        lay_data[3] = 24'h000000;
        lay_data[2] = 24'h00FF00;
        lay_data[1] = 24'h000000;
        lay_data[0] = 24'h112233;
        run_pixel(5'b11111, 1, 0, 0, 1'b0);
        // No layers enabled.
        run_pixel(5'b00000, 1, 0, 0, 1'b0);
        // Top and background only, request held across a ready stall.
        lay_data[0] = 24'h445566;
        run_pixel(5'b10001, 1, 3, 0, 1'b0);
        // Composer back-pressure with a competing start request.
        lay_data[3] = 24'h123456;
        run_pixel(5'b01110, 2, 0, 5, 1'b1);
        // Opaque top layer.
        lay_data[4] = 24'hFF0000;
        lay_data[3] = 24'h0000FF;
        lay_data[1] = 24'h777777;
        run_pixel(5'b11111, 1, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NL; i++)
                lay_data[i] = ($urandom_range(0, 2) == 0) ? TRANSPARENT_PIX
                                                          : PW'($urandom_range(1, 32'hFFFFFF));
            run_pixel(NL'($urandom), $urandom_range(1, 3), $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Stray response while idle sets the sticky flag.
        chk("unexp_before_stray", 128'(bus.rsp_unexp), 128'(0));
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        exp_unexp = 1'b1;
        chk("unexp_after_stray", 128'(bus.rsp_unexp), 128'(1));
        run_pixel(5'b10101, 2, 1, 1, 1'b0);
        chk("unexp_sticky", 128'(bus.rsp_unexp), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
